// File: rtl/efuse_cfg_loader.sv
// Boot-time loader: reads NUM_BYTES efuse bytes over Wishbone and shifts them LSB-first into the config chain.
// Optional build macro EFUSE_CFG_LOADER_TIMEOUT_EN adds a per-request ack timeout that aborts into ERR.
module efuse_cfg_loader #(
   parameter logic [11:0] BASE_ADDR      = 12'h000,
   parameter int          NUM_BYTES      = 16,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic        wb_sel_o,
   output logic [11:0] wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   input  logic        wb_ack_i,
   output logic        cfg_shift_o,
   output logic        cfg_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   if (NUM_BYTES < 1 || NUM_BYTES > 4096 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("efuse_cfg_loader: NUM_BYTES must be 1..4096 and TIMEOUT_CYCLES >= 1");
   end

   logic [2:0]    state, state_nx;
   logic [11:0]   adr, adr_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0]    sreg, sreg_nx;
   logic [2:0]    bit_cnt, bit_nx;

`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wait_cnt, wait_nx;
`endif

   // Bus handshake: classic single-beat read. cyc/stb rise on REQ entry and stay
   // high with a stable address until wb_ack_i is seen high on a clock edge; the
   // data on wb_dat_i is captured at that same edge and cyc/stb drop the next cycle.
   always_comb begin
      state_nx = state;
      adr_nx   = adr;
      cnt_nx   = cnt;
      sreg_nx  = sreg;
      bit_nx   = bit_cnt;
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
      wait_nx  = wait_cnt;
`endif
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_nx = S_REQ;
               adr_nx   = BASE_ADDR;
               cnt_nx   = '0;
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
               wait_nx  = '0;
`endif
            end
         end
         S_REQ: begin
            if (wb_ack_i) begin
               state_nx = S_SHIFT;
               sreg_nx  = wb_dat_i;
               bit_nx   = 3'd0;
            end
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
            else if (wait_cnt == WAIT_LAST) begin
               state_nx = S_ERR;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
`endif
         end
         S_SHIFT: begin
            sreg_nx = {1'b0, sreg[7:1]};
            bit_nx  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (cnt == LAST_CNT) begin
                  state_nx = S_DONE;
               end else begin
                  // 12-bit address wraps from 12'hFFF to 12'h000 naturally
                  state_nx = S_REQ;
                  adr_nx   = adr + 12'd1;
                  cnt_nx   = cnt + 1'b1;
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
                  wait_nx  = '0;
`endif
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= S_IDLE;
         adr      <= BASE_ADDR;
         cnt      <= '0;
         sreg     <= 8'h00;
         bit_cnt  <= 3'd0;
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         state    <= state_nx;
         adr      <= adr_nx;
         cnt      <= cnt_nx;
         sreg     <= sreg_nx;
         bit_cnt  <= bit_nx;
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
         wait_cnt <= wait_nx;
`endif
      end
   end

   // Outputs decode straight from state so an async reset drops cyc/stb immediately.
   assign wb_cyc_o    = (state == S_REQ);
   assign wb_stb_o    = wb_cyc_o;
   assign wb_we_o     = 1'b0;
   assign wb_sel_o    = 1'b1;
   assign wb_adr_o    = adr;
   assign wb_dat_o    = 8'h00;
   assign cfg_shift_o = (state == S_SHIFT);
   assign cfg_data_o  = cfg_shift_o & sreg[0];
   assign busy_o      = (state == S_REQ) || (state == S_SHIFT);
   assign done_o      = (state == S_DONE);
`ifdef EFUSE_CFG_LOADER_TIMEOUT_EN
   assign err_o       = (state == S_ERR);
`else
   assign err_o       = 1'b0;
`endif

endmodule
